// File: rtl/lamp_key_ctrl_if.sv
// Button/lamp signal bundle between the key front end and its environment.
interface lamp_key_ctrl_if;
    logic [1:0] Key;
    logic       fake_switch;
    logic       busy;
    logic [1:0] key_evt;

    modport master (output Key, input fake_switch, input busy, input key_evt);
    modport slave  (input Key, output fake_switch, output busy, output key_evt);
endinterface

// File: rtl/lamp_key_ctrl.sv
// Key front end for the three-colour lamp: sync + debounce per button, power/blip FSM on fake_switch.
// Build macro AUTO_REPEAT_EN: a held Key[1] keeps issuing colour blips every REPEAT_CYC cycles.
module lamp_key_ctrl #(
    parameter int DEBOUNCE_CYC = 200,
    parameter int BLIP_CYC     = 50,
    parameter int REPEAT_CYC   = 5000,
    parameter int CNT_W        = 16
) (
    input  logic           Div_CLK,
    input  logic           Sys_RST,
    lamp_key_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] BLIP_LAST = CNT_W'(BLIP_CYC - 1);

    typedef enum logic [1:0] {ST_OFF, ST_ON, ST_BLIP} state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] blip_cnt_reg;
    logic             fake_switch_reg;
    logic             busy_reg;
    logic [1:0]       key_evt;
    logic             rep_fire;
    logic             blip_req;

    genvar gi;
    generate
        if (DEBOUNCE_CYC < 2 || DEBOUNCE_CYC >= 2**CNT_W) begin : g_bad_debounce
            $error("lamp_key_ctrl: DEBOUNCE_CYC out of range");
        end
        if (BLIP_CYC < 1 || BLIP_CYC >= 2**CNT_W) begin : g_bad_blip
            $error("lamp_key_ctrl: BLIP_CYC out of range");
        end
        if (REPEAT_CYC < 1 || REPEAT_CYC >= 2**CNT_W) begin : g_bad_repeat
            $error("lamp_key_ctrl: REPEAT_CYC out of range");
        end

        for (gi = 0; gi < 2; gi++) begin : g_key
            logic             s1_reg;
            logic             s2_reg;
            logic             stable_reg;
            logic             stable_d_reg;
            logic [CNT_W-1:0] db_cnt_reg;

            always_ff @(posedge Div_CLK) begin
                if (!Sys_RST) begin
                    s1_reg       <= 1'b1;
                    s2_reg       <= 1'b1;
                    stable_reg   <= 1'b1;
                    stable_d_reg <= 1'b1;
                    db_cnt_reg   <= '0;
                end else begin
                    s1_reg       <= bus.Key[gi];
                    s2_reg       <= s1_reg;
                    stable_d_reg <= stable_reg;
                    // any sample matching the accepted level restarts the stability count
                    if (s2_reg == stable_reg) begin
                        db_cnt_reg <= '0;
                    end else if (db_cnt_reg == DB_LAST) begin
                        stable_reg <= s2_reg;
                        db_cnt_reg <= '0;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + CNT_W'(1);
                    end
                end
            end

            assign key_evt[gi] = stable_d_reg & ~stable_reg;
        end
    endgenerate

`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYC - 1);

    logic [CNT_W-1:0] rep_cnt_reg;
    logic             rep_run;

    assign rep_run  = ~g_key[1].stable_reg && (state_reg != ST_OFF);
    assign rep_fire = rep_run && (state_reg == ST_ON) && (rep_cnt_reg == REP_LAST)
                      && !key_evt[0] && !key_evt[1];

    // the genuine press restarts the period; the count parks at its last value during a blip
    always_ff @(posedge Div_CLK) begin
        if (!Sys_RST) begin
            rep_cnt_reg <= '0;
        end else if (!rep_run || key_evt[0] || key_evt[1] || rep_fire) begin
            rep_cnt_reg <= '0;
        end else if (rep_cnt_reg != REP_LAST) begin
            rep_cnt_reg <= rep_cnt_reg + CNT_W'(1);
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign blip_req = key_evt[1] | rep_fire;

    always_ff @(posedge Div_CLK) begin
        if (!Sys_RST) begin
            state_reg       <= ST_OFF;
            blip_cnt_reg    <= '0;
            fake_switch_reg <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            case (state_reg)
                ST_OFF: begin
                    if (key_evt[0]) begin
                        state_reg       <= ST_ON;
                        fake_switch_reg <= 1'b1;
                        busy_reg        <= 1'b0;
                    end
                end
                ST_ON: begin
                    // power key has priority over a colour request in the same cycle
                    if (key_evt[0]) begin
                        state_reg       <= ST_OFF;
                        fake_switch_reg <= 1'b0;
                        busy_reg        <= 1'b0;
                    end else if (blip_req) begin
                        state_reg       <= ST_BLIP;
                        blip_cnt_reg    <= '0;
                        fake_switch_reg <= 1'b0;
                        busy_reg        <= 1'b1;
                    end
                end
                ST_BLIP: begin
                    if (key_evt[0]) begin
                        state_reg       <= ST_OFF;
                        fake_switch_reg <= 1'b0;
                        busy_reg        <= 1'b0;
                    end else if (blip_cnt_reg == BLIP_LAST) begin
                        state_reg       <= ST_ON;
                        fake_switch_reg <= 1'b1;
                        busy_reg        <= 1'b0;
                    end else begin
                        blip_cnt_reg <= blip_cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg       <= ST_OFF;
                    fake_switch_reg <= 1'b0;
                    busy_reg        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fake_switch = fake_switch_reg;
    assign bus.busy        = busy_reg;
    assign bus.key_evt     = key_evt;
endmodule

// File: tb/tb_lamp_key_ctrl.sv
// Randomised and directed bench for lamp_key_ctrl against a cycle-level behavioural model.
module tb_lamp_key_ctrl;
    localparam int DB = 4;
    localparam int BL = 3;
    localparam int RP = 10;

    logic Div_CLK = 1'b0;
    logic Sys_RST = 1'b0;

    lamp_key_ctrl_if bus();

    lamp_key_ctrl #(
        .DEBOUNCE_CYC(DB),
        .BLIP_CYC    (BL),
        .REPEAT_CYC  (RP),
        .CNT_W       (16)
    ) dut (
        .Div_CLK(Div_CLK),
        .Sys_RST(Sys_RST),
        .bus    (bus)
    );

    always #5 Div_CLK = ~Div_CLK;

    int n_total = 0;
    int n_bad   = 0;

    // model: raw key history, s2-level history, accepted levels, lamp power and blip countdown
    bit [1:0] samp_q[$];
    bit [1:0] s2_q[$];
    bit       m_rst_last = 1'b1;
    bit [1:0] m_stab     = 2'b11;
    bit [1:0] m_evt      = 2'b00;
    bit       m_pwr      = 1'b0;
    int       m_blip_left = 0;
    int       m_age       = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst_n, input logic [1:0] key);
        bit [1:0] s2_now;
        bit       all_diff;
        bit       held;
        bit       due;
        if (!rst_n) begin
            samp_q.push_back(2'b11);
            s2_q.push_back(2'b11);
            m_rst_last  = 1'b1;
            m_stab      = 2'b11;
            m_evt       = 2'b00;
            m_pwr       = 1'b0;
            m_blip_left = 0;
            m_age       = 0;
        end else begin
            s2_now = m_rst_last ? 2'b11 : samp_q[samp_q.size()-2];
            samp_q.push_back(key);
            s2_q.push_back(s2_now);
            m_rst_last = 1'b0;

            held = !m_stab[1] && m_pwr;
            due  = 1'b0;
`ifdef AUTO_REPEAT_EN
            due = held && m_blip_left == 0 && m_age == RP - 1 && !m_evt[0] && !m_evt[1];
            if (!held || m_evt[0] || m_evt[1] || due) m_age = 0;
            else if (m_age < RP - 1) m_age++;
`endif
            if (m_evt[0]) begin
                m_pwr       = !m_pwr;
                m_blip_left = 0;
            end else if (m_blip_left > 0) begin
                m_blip_left--;
            end else if (m_pwr && (m_evt[1] || due)) begin
                m_blip_left = BL;
            end

            // a level is accepted once the last DB synchronised samples all disagree with it
            for (int i = 0; i < 2; i++) begin
                all_diff = 1'b1;
                for (int j = 0; j < DB; j++)
                    if (s2_q[s2_q.size()-1-j][i] == m_stab[i]) all_diff = 1'b0;
                m_evt[i] = all_diff & m_stab[i];
                if (all_diff) m_stab[i] = ~m_stab[i];
            end
        end
        while (samp_q.size() > 64) void'(samp_q.pop_front());
        while (s2_q.size() > 64) void'(s2_q.pop_front());
    endtask

    task automatic tick();
        @(posedge Div_CLK);
        model_edge(Sys_RST, bus.Key);
        @(negedge Div_CLK);
        check_eq("fake_switch", {31'd0, bus.fake_switch}, {31'd0, m_pwr && m_blip_left == 0});
        check_eq("busy",        {31'd0, bus.busy},        {31'd0, m_blip_left > 0});
        check_eq("key_evt",     {30'd0, bus.key_evt},     {30'd0, m_evt});
    endtask

    task automatic hold(input logic [1:0] k, input int cycles);
        bus.Key = k;
        repeat (cycles) tick();
    endtask

    initial begin
        int rise;
        int toggles;
        int low_cnt;
        int blips;
        bit busy_seen;
        bit prev_f;
        bit prev_b;
        bit found;

        for (int i = 0; i < 2; i++) samp_q.push_back(2'b11);
        for (int i = 0; i < DB; i++) s2_q.push_back(2'b11);

        bus.Key = 2'b11;
        Sys_RST = 1'b0;
        repeat (2) tick();
        Sys_RST = 1'b1;
        hold(2'b11, 20);
        check_eq("reset_fake", {31'd0, bus.fake_switch}, 32'd0);
        $display("reset: held 2 cycles, idle 20, fake_switch=%0b busy=%0b", bus.fake_switch, bus.busy);

        bus.Key = 2'b10;
        rise = 0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (bus.fake_switch && rise == 0) rise = e;
        end
        check_eq("rise_edge", rise, DB + 3);
        hold(2'b11, 10);
        hold(2'b10, 10);
        hold(2'b11, 10);
        check_eq("power_off", {31'd0, bus.fake_switch}, 32'd0);
        $display("power key: on at edge %0d, second press off", rise);

        toggles = 0;
        prev_f  = bus.fake_switch;
        for (int i = 0; i < 28; i++) begin
            bus.Key = (i < 4) ? {1'b1, i[0]} : (i < 16 ? 2'b10 : 2'b11);
            tick();
            if (bus.fake_switch != prev_f) toggles++;
            prev_f = bus.fake_switch;
        end
        check_eq("bounce_toggles", toggles, 1);
        $display("bounce: toggles=%0d", toggles);

        low_cnt = 0;
        for (int i = 0; i < 22; i++) begin
            bus.Key = (i < 8) ? 2'b01 : 2'b11;
            tick();
            if (!bus.fake_switch) low_cnt++;
        end
        check_eq("blip_len", low_cnt, BL);
        $display("colour key in ON: low for %0d cycles", low_cnt);

        hold(2'b01, 1);
        busy_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.Key = 2'b00;
            tick();
            if (bus.busy) busy_seen = 1'b1;
        end
        check_eq("abort_saw_blip", {31'd0, busy_seen}, 32'd1);
        hold(2'b11, 12);
        check_eq("abort_fake", {31'd0, bus.fake_switch}, 32'd0);
        check_eq("abort_busy", {31'd0, bus.busy}, 32'd0);
        $display("power during blip: fake_switch=%0b busy=%0b", bus.fake_switch, bus.busy);

        hold(2'b01, 10);
        hold(2'b11, 10);
        check_eq("colour_in_off", {31'd0, bus.fake_switch}, 32'd0);
        hold(2'b10, 10);
        hold(2'b11, 10);
        busy_seen = 1'b0;
        for (int i = 0; i < 22; i++) begin
            bus.Key = (i < 10) ? 2'b00 : 2'b11;
            tick();
            if (bus.busy) busy_seen = 1'b1;
        end
        check_eq("simul_no_blip", {31'd0, busy_seen}, 32'd0);
        check_eq("simul_off", {31'd0, bus.fake_switch}, 32'd0);
        $display("both keys together from ON: fake_switch=%0b blip_seen=%0b", bus.fake_switch, busy_seen);

        hold(2'b10, 10);
        hold(2'b11, 10);
        blips  = 0;
        prev_b = 1'b0;
        for (int i = 0; i < 60; i++) begin
            bus.Key = (i < 40) ? 2'b01 : 2'b11;
            tick();
            if (bus.busy && !prev_b) blips++;
            prev_b = bus.busy;
        end
`ifdef AUTO_REPEAT_EN
        check_eq("held_blips", blips, 4);
`else
        check_eq("held_blips", blips, 1);
`endif
        $display("colour key held 40 cycles: blips=%0d", blips);

        for (int s = 0; s < 80; s++) begin
            int len;
            if ($urandom_range(0, 25) == 0) begin
                Sys_RST = 1'b0;
                hold(2'($urandom_range(0, 3)), $urandom_range(1, 3));
                Sys_RST = 1'b1;
            end
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 20);
            hold(2'($urandom_range(0, 3)), len);
            $display("random seg %0d: Key=%b len=%0d fake_switch=%0b busy=%0b",
                     s, bus.Key, len, bus.fake_switch, bus.busy);
        end

        found = 1'b0;
        Sys_RST = 1'b0;
        hold(2'b11, 2);
        Sys_RST = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            hold(2'b11, 1);
            if (bus.key_evt == 2'b00 && !bus.fake_switch) found = 1'b1;
        end
        check_eq("final_idle", {31'd0, found}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/lamp_key_ctrl.md
Name: lamp_key_ctrl

Overview:
- Front end that turns the two raw push-buttons Key[1:0] into the fake_switch level consumed by the three-colour lamp FSM.
- Key[0] is the power toggle. Key[1] is "next colour": it emits a short off-on blip on fake_switch, which the lamp FSM reads as a quick re-switch and uses to advance the colour.
- Contains a synchronizer and debouncer per key, plus a 3-state output FSM. Runs on Div_CLK (10 kHz nominal).

Parameters:
- DEBOUNCE_CYC, 200: consecutive stable cycles needed to accept a key level change (20 ms at 10 kHz). Must be >= 2.
- BLIP_CYC, 50: cycles fake_switch is held low during a colour blip. Must be >= 1 and well below the lamp wait window (10000).
- REPEAT_CYC, 5000: auto-repeat period in cycles. Used only with AUTO_REPEAT_EN.
- CNT_W, 16: width of all internal counters. Every *_CYC value must be < 2^CNT_W.

Ports:
- Div_CLK  input  1  system clock; all logic on its rising edge.
- Sys_RST  input  1  synchronous, active-low reset.
- Key  input  2  raw buttons, asynchronous, active-low (0 = pressed). Key[0] is power, Key[1] is next colour.
- fake_switch  output  1  lamp switch level to the lamp FSM; 1 = on.
- busy  output  1  high while a blip is in progress.
- key_evt  output  2  one-cycle debounced press pulse per key; driven only from registers.

Behaviour:
- Reset, sampled when Sys_RST=0 at a rising edge:
  - sync flops and stable key levels go to 1 (released); debounce and blip counters go to 0; FSM goes to OFF.
  - fake_switch=0, busy=0, key_evt=0.
  - Reset in any state, including mid-blip or mid-debounce, aborts the operation; no pending event survives.
- Synchronizer: two flops per key, s1<=Key and s2<=s1.
- Debounce, per key:
  - If s2 != stable: cnt<=cnt+1. When cnt==DEBOUNCE_CYC-1, stable<=s2 and cnt<=0.
  - If s2 == stable: cnt<=0. Any bounce restarts the count.
- Press event, per key: stable_d<=stable; key_evt = stable_d & ~stable, i.e. the 1->0 transition of the stable level. Releases produce no event.
- Latency: fake_switch changes at the (DEBOUNCE_CYC+3)-th rising edge after the first edge that samples Key low, provided Key is held low throughout.
- FSM states: OFF, ON, BLIP.
  - OFF: fake_switch=0. evt0 -> ON. evt1 is ignored.
  - ON: fake_switch=1. evt0 -> OFF. evt1 -> BLIP with blip_cnt<=0.
  - BLIP: fake_switch=0, busy=1, blip_cnt increments each cycle. When blip_cnt==BLIP_CYC-1 -> ON, so fake_switch is low for exactly BLIP_CYC cycles. evt0 -> OFF, aborting the blip. evt1 is ignored.
- Simultaneous evt0 and evt1 in the same cycle: evt0 wins and evt1 is dropped.
- Outputs are Moore: fake_switch and busy are decoded from the registered state.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined:
  - While the stable Key[1] level is pressed and the FSM is in ON or BLIP, a repeat counter runs.
  - Each time it reaches REPEAT_CYC-1 after the initial press, and the FSM is in ON, an extra BLIP is started and the counter clears.
  - The counter clears on Key[1] release, on evt0, and on reset.
  - key_evt[1] does not pulse for repeats.
- Not defined: the repeat counter is absent; exactly one blip per press.

Test Plan (bench overrides DEBOUNCE_CYC=4, BLIP_CYC=3, REPEAT_CYC=10):
- Reset with Sys_RST=0 for 2 cycles, Key=2'b11 -> fake_switch=0, busy=0, key_evt=0; outputs hold for 20 cycles after release.
- Key[0] low held 10 cycles -> key_evt[0] pulses for 1 cycle; fake_switch rises at edge 7 after first low sample. Second press -> fake_switch=0.
- Key[0] bounce 0,1,0,1 (1 cycle each), then held 0 -> no event until 4 consecutive low s2 samples; exactly one toggle.
- In ON, press Key[1] -> fake_switch low for exactly 3 cycles with busy=1, then back to 1. Press Key[1] in OFF -> no change.
- In BLIP, press Key[0] -> OFF, fake_switch stays 0, busy=0. Key[0] and Key[1] pressed on the same cycle from ON -> OFF, no blip.
- AUTO_REPEAT_EN defined, Key[1] held 40 cycles in ON -> first blip on press, further blips every 10 cycles while held; none after release. Without the macro -> exactly one blip.
